// File: rtl/ahb_button_ctrl_if.sv
// AHB-Lite bus bundle for the push-button controller.
interface ahb_button_ctrl_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_button_ctrl.sv
// AHB-Lite button controller: synchronise, debounce, latch presses,
// count them and raise a maskable level interrupt.
module ahb_button_ctrl #(
    parameter int NUM_BUTTONS     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    ahb_button_ctrl_if.slave       bus,
    input  logic [NUM_BUTTONS-1:0] buttons_n,
    output logic                   irq
);
    localparam int CW  = $clog2(DEBOUNCE_CYCLES);
    localparam int NRD = (NUM_BUTTONS < 4) ? NUM_BUTTONS : 4;
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        A_STATUS  = 2'd0,
        A_PENDING = 2'd1,
        A_IRQ_EN  = 2'd2,
        A_COUNT   = 2'd3
    } reg_addr_e;

    logic [NUM_BUTTONS-1:0] sync1_q, sync2_q;
    logic [NUM_BUTTONS-1:0] stable_q, stable_d;
    logic [NUM_BUTTONS-1:0] pend_q, pend_d;
    logic [NUM_BUTTONS-1:0] irq_en_q, irq_en_d;
    logic [NUM_BUTTONS-1:0] press;
    logic [CW-1:0]          db_q  [NUM_BUTTONS];
    logic [CW-1:0]          db_d  [NUM_BUTTONS];
    logic [7:0]             cnt_q [NUM_BUTTONS];
    logic [7:0]             cnt_d [NUM_BUTTONS];
    logic                   dp_valid_q;
    logic                   dp_write_q;
    reg_addr_e              dp_addr_q;
    logic                   irq_q;
    logic                   wr_en, wr_pend, wr_irq_en, wr_cnt;
    logic [NUM_BUTTONS-1:0] wdata;
    logic [31:0]            cnt_word;
    logic [31:0]            rdata;
    logic                   unused_bits;

    always_comb begin
        stable_d = stable_q;
        press    = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            db_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (db_q[i] == DB_LAST) begin
                    stable_d[i] = sync2_q[i];
                    press[i]    = sync2_q[i];
                end else begin
                    db_d[i] = db_q[i] + CW'(1);
                end
            end
        end
    end

    assign wr_en     = dp_valid_q & dp_write_q & bus.HREADY;
    assign wr_pend   = wr_en & (dp_addr_q == A_PENDING);
    assign wr_irq_en = wr_en & (dp_addr_q == A_IRQ_EN);
    assign wr_cnt    = wr_en & (dp_addr_q == A_COUNT);
    assign wdata     = bus.HWDATA[NUM_BUTTONS-1:0];

    // A new press always beats a same-cycle clear or counter reset.
    always_comb begin
        pend_d   = (pend_q & ~(wr_pend ? wdata : '0)) | press;
        irq_en_d = wr_irq_en ? wdata : irq_en_q;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            cnt_d[i] = (wr_cnt ? 8'd0 : cnt_q[i]) + {7'd0, press[i]};
        end
    end

    always_comb begin
        cnt_word = '0;
        for (int i = 0; i < NRD; i++) begin
            cnt_word[8*i +: 8] = cnt_q[i];
        end
        rdata = '0;
        if (dp_valid_q && !dp_write_q) begin
            unique case (dp_addr_q)
                A_STATUS:  rdata = 32'(stable_q);
                A_PENDING: rdata = 32'(pend_q);
                A_IRQ_EN:  rdata = 32'(irq_en_q);
                A_COUNT:   rdata = cnt_word;
            endcase
        end
    end

    // Synchroniser holds the pressed (active-high) level so reset means released.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            stable_q   <= '0;
            pend_q     <= '0;
            irq_en_q   <= '0;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                db_q[i]  <= '0;
                cnt_q[i] <= '0;
            end
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_addr_q  <= A_STATUS;
            irq_q      <= 1'b0;
        end else begin
            sync1_q  <= ~buttons_n;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            pend_q   <= pend_d;
            irq_en_q <= irq_en_d;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                db_q[i]  <= db_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            if (bus.HREADY) begin
                dp_valid_q <= bus.HSEL & bus.HTRANS[1];
                dp_write_q <= bus.HWRITE;
                dp_addr_q  <= reg_addr_e'(bus.HADDR[3:2]);
            end
            irq_q <= |(pend_q & irq_en_q);
        end
    end

    assign bus.HRDATA    = rdata;
    assign bus.HREADYOUT = 1'b1;
    assign bus.HRESP     = 1'b0;
    assign irq           = irq_q;

    assign unused_bits = ^{bus.HSIZE, bus.HADDR[31:4], bus.HADDR[1:0],
                           bus.HWDATA[31:NUM_BUTTONS], bus.HTRANS[0]};
endmodule

// File: tb/tb_ahb_button_ctrl.sv
// Bench for ahb_button_ctrl: register table, read scoreboard and
// hand-timed debounce, collision, wrap and reset sequences.
module tb_ahb_button_ctrl;
    localparam int NB = 2;
    localparam logic [1:0] R_STATUS = 2'd0;
    localparam logic [1:0] R_PEND   = 2'd1;
    localparam logic [1:0] R_IRQEN  = 2'd2;
    localparam logic [1:0] R_COUNT  = 2'd3;

    typedef struct {
        string       name;
        bit          wr;
        logic [1:0]  addr;
        logic [31:0] data;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic [NB-1:0] buttons_n;
    logic          irq;
    logic          mon_rd;
    int            n_vec = 0;
    int            n_err = 0;
    sb_t           sbq[$];
    sb_t           sb_e;
    vec_t          tbl[14];

    ahb_button_ctrl_if bif();

    ahb_button_ctrl #(
        .NUM_BUTTONS(NB),
        .DEBOUNCE_CYCLES(16)
    ) dut (
        .HCLK(HCLK),
        .HRESETn(HRESETn),
        .bus(bif),
        .buttons_n(buttons_n),
        .irq(irq)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle();
        bif.HSEL   = 1'b0;
        bif.HTRANS = 2'b00;
        bif.HWRITE = 1'b0;
        bif.HADDR  = '0;
        bif.HSIZE  = 3'b010;
        bif.HREADY = 1'b1;
    endtask

    task automatic addr_phase(input logic [1:0] a, input logic w);
        bif.HSEL   = 1'b1;
        bif.HTRANS = 2'b10;
        bif.HWRITE = w;
        bif.HADDR  = {28'h0, a, 2'b00};
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e,
                      input string nm);
        addr_phase(a, 1'b0);
        sbq.push_back('{nm, e});
        cyc();
        idle();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr_phase(a, 1'b1);
        cyc();
        idle();
        bif.HWDATA = d;
        cyc();
    endtask

    // Write immediately followed by a read of the same register.
    task automatic wr_rd(input logic [1:0] a, input logic [31:0] d,
                         input logic [31:0] e, input string nm);
        addr_phase(a, 1'b1);
        cyc();
        addr_phase(a, 1'b0);
        bif.HWDATA = d;
        sbq.push_back('{nm, e});
        cyc();
        idle();
    endtask

    task automatic press(input int b, input int hold, input int gap);
        buttons_n[b] = 1'b0;
        repeat (hold) cyc();
        buttons_n[b] = 1'b1;
        repeat (gap) cyc();
    endtask

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) mon_rd <= 1'b0;
        else if (bif.HREADY) mon_rd <= bif.HSEL & bif.HTRANS[1] & ~bif.HWRITE;
    end

    always @(negedge HCLK) begin
        if (mon_rd && sbq.size() > 0) begin
            sb_e = sbq.pop_front();
            chk(sb_e.name, bif.HRDATA, sb_e.exp);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        tbl[0]  = '{"rst_status",   1'b0, R_STATUS, 32'h0};
        tbl[1]  = '{"rst_pending",  1'b0, R_PEND,   32'h0};
        tbl[2]  = '{"rst_irq_en",   1'b0, R_IRQEN,  32'h0};
        tbl[3]  = '{"rst_count",    1'b0, R_COUNT,  32'h0};
        tbl[4]  = '{"w_irq_en",     1'b1, R_IRQEN,  32'hFFFF_FFFF};
        tbl[5]  = '{"irq_en_mask",  1'b0, R_IRQEN,  32'h3};
        tbl[6]  = '{"w_status",     1'b1, R_STATUS, 32'h3};
        tbl[7]  = '{"status_ro",    1'b0, R_STATUS, 32'h0};
        tbl[8]  = '{"w_pending",    1'b1, R_PEND,   32'h3};
        tbl[9]  = '{"pending_w1c0", 1'b0, R_PEND,   32'h0};
        tbl[10] = '{"w_count",      1'b1, R_COUNT,  32'h1234_5678};
        tbl[11] = '{"count_clr",    1'b0, R_COUNT,  32'h0};
        tbl[12] = '{"w_irq_en0",    1'b1, R_IRQEN,  32'h0};
        tbl[13] = '{"irq_en_zero",  1'b0, R_IRQEN,  32'h0};

        HRESETn   = 1'b0;
        buttons_n = '1;
        bif.HWDATA = '0;
        idle();
        #23;
        chk("irq_in_reset", 32'(irq), 32'h0);
        chk("hrdata_in_reset", bif.HRDATA, 32'h0);
        cyc();
        HRESETn = 1'b1;
        repeat (4) cyc();
        chk("hreadyout", 32'(bif.HREADYOUT), 32'h1);
        chk("hresp", 32'(bif.HRESP), 32'h0);
        chk("hrdata_idle", bif.HRDATA, 32'h0);

        for (int i = 0; i < 14; i++) begin
            if (tbl[i].wr) wr(tbl[i].addr, tbl[i].data);
            else rd(tbl[i].addr, tbl[i].data, tbl[i].name);
        end
        cyc();
        chk("irq_after_table", 32'(irq), 32'h0);

        // Clean press on button 0; irq expected on the 19th edge.
        wr(R_IRQEN, 32'h1);
        buttons_n[0] = 1'b0;
        n = 0;
        while (n < 40 && !irq) begin
            cyc();
            n++;
        end
        chk("press_to_irq_edges", 32'(n), 32'd19);
        rd(R_STATUS, 32'h1, "status_held");
        rd(R_PEND, 32'h1, "pending_press");
        rd(R_COUNT, 32'h1, "count_press");
        repeat (28) cyc();
        buttons_n[0] = 1'b1;
        repeat (22) cyc();
        rd(R_STATUS, 32'h0, "status_released");
        wr(R_PEND, 32'h1);
        chk("irq_clr_lag", 32'(irq), 32'h1);
        cyc();
        chk("irq_clr_fall", 32'(irq), 32'h0);

        buttons_n[1] = 1'b0; repeat (10) cyc();
        buttons_n[1] = 1'b1; repeat (2) cyc();
        buttons_n[1] = 1'b0; repeat (10) cyc();
        buttons_n[1] = 1'b1; repeat (25) cyc();
        rd(R_PEND, 32'h0, "bounce_pending");
        rd(R_COUNT, 32'h1, "bounce_count");
        press(1, 20, 22);
        rd(R_PEND, 32'h2, "hold_pending");
        rd(R_COUNT, 32'h101, "hold_count");
        chk("irq_masked_b1", 32'(irq), 32'h0);

        press(0, 20, 22);
        rd(R_PEND, 32'h3, "pending_both");
        wr_rd(R_IRQEN, 32'h2, 32'h2, "irq_en_b2b");
        cyc();
        chk("irq_b1_enabled", 32'(irq), 32'h1);
        wr(R_PEND, 32'h2);
        chk("irq_w1c_lag", 32'(irq), 32'h1);
        cyc();
        chk("irq_w1c_fall", 32'(irq), 32'h0);
        rd(R_PEND, 32'h1, "pending_after_w1c");
        wr(R_IRQEN, 32'h0);
        repeat (2) cyc();
        chk("irq_en_off", 32'(irq), 32'h0);

        // W1C data phase lands on the same edge as the press event.
        wr(R_PEND, 32'h1);
        rd(R_PEND, 32'h0, "pending_cleared");
        buttons_n[0] = 1'b0;
        repeat (16) cyc();
        wr(R_PEND, 32'h1);
        rd(R_PEND, 32'h1, "collide_w1c");
        repeat (5) cyc();
        buttons_n[0] = 1'b1;
        repeat (22) cyc();
        rd(R_COUNT, 32'h103, "count_three");

        buttons_n[1] = 1'b0;
        repeat (16) cyc();
        wr(R_COUNT, 32'h0);
        rd(R_COUNT, 32'h100, "collide_count");
        repeat (5) cyc();
        buttons_n[1] = 1'b1;
        repeat (22) cyc();
        rd(R_PEND, 32'h3, "pending_after_cnt");

        wr(R_COUNT, 32'h0);
        rd(R_COUNT, 32'h0, "count_zeroed");
        for (int k = 0; k < 255; k++) press(0, 20, 22);
        rd(R_COUNT, 32'hFF, "count_255");
        press(0, 20, 22);
        rd(R_COUNT, 32'h0, "count_wrap");

        wr(R_IRQEN, 32'h1);
        cyc();
        chk("irq_before_rst", 32'(irq), 32'h1);
        buttons_n[0] = 1'b0;
        repeat (10) cyc();
        addr_phase(R_IRQEN, 1'b0);
        cyc();
        idle();
        chk("hrdata_before_rst", bif.HRDATA, 32'h1);
        #1 HRESETn = 1'b0;
        #1;
        chk("irq_mid_rst", 32'(irq), 32'h0);
        chk("hrdata_mid_rst", bif.HRDATA, 32'h0);
        repeat (3) cyc();
        HRESETn = 1'b1;
        rd(R_STATUS, 32'h0, "status_after_rst");
        repeat (15) cyc();
        rd(R_STATUS, 32'h0, "status_edge17");
        rd(R_STATUS, 32'h1, "status_edge18");
        rd(R_PEND, 32'h1, "pending_held_rst");
        rd(R_COUNT, 32'h1, "count_held_rst");
        buttons_n[0] = 1'b1;
        repeat (22) cyc();
        chk("irq_en_rst_clear", 32'(irq), 32'h0);
        chk("scoreboard_drained", 32'(sbq.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
